// File: rtl/ps2_key_pkg.sv
// Shared constants, parser states, event record and scancode-to-keycode map
// for the PS/2 key event decoder.
package ps2_key_pkg;

   localparam logic [7:0] SC_E0     = 8'hE0;
   localparam logic [7:0] SC_E1     = 8'hE1;
   localparam logic [7:0] SC_F0     = 8'hF0;
   localparam logic [7:0] SC_BAT    = 8'hAA;
   localparam logic [7:0] SC_ACK    = 8'hFA;
   localparam logic [7:0] SC_RESEND = 8'hFE;
   localparam logic [7:0] SC_ERR0   = 8'h00;
   localparam logic [7:0] SC_ERR1   = 8'hFF;

   localparam logic [7:0] KEY_SPACE = 8'd36;
   localparam logic [7:0] KEY_BKSP  = 8'd37;
   localparam logic [7:0] KEY_DOT   = 8'd38;
   localparam logic [7:0] KEY_ENTER = 8'd98;
   localparam logic [7:0] KEY_DOWN  = 8'd99;
   localparam logic [7:0] KEY_UP    = 8'd100;
   localparam logic [7:0] KEY_NONE  = 8'd255;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_PAUSE
   } parse_state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       brk;
      logic       ext;
      logic [7:0] raw;
   } key_evt_t;

   function automatic logic is_ignored(input logic [7:0] b);
      return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) ||
             (b == SC_ERR0) || (b == SC_ERR1);
   endfunction

   function automatic logic [7:0] map_scancode(input logic [7:0] sc);
      logic [7:0] k;
      case (sc)
         8'h45: k = 8'd0;
         8'h16: k = 8'd1;
         8'h1E: k = 8'd2;
         8'h26: k = 8'd3;
         8'h25: k = 8'd4;
         8'h2E: k = 8'd5;
         8'h36: k = 8'd6;
         8'h3D: k = 8'd7;
         8'h3E: k = 8'd8;
         8'h46: k = 8'd9;
         8'h1C: k = 8'd10;
         8'h32: k = 8'd11;
         8'h21: k = 8'd12;
         8'h23: k = 8'd13;
         8'h24: k = 8'd14;
         8'h2B: k = 8'd15;
         8'h34: k = 8'd16;
         8'h33: k = 8'd17;
         8'h43: k = 8'd18;
         8'h3B: k = 8'd19;
         8'h42: k = 8'd20;
         8'h4B: k = 8'd21;
         8'h3A: k = 8'd22;
         8'h31: k = 8'd23;
         8'h44: k = 8'd24;
         8'h4D: k = 8'd25;
         8'h15: k = 8'd26;
         8'h2D: k = 8'd27;
         8'h1B: k = 8'd28;
         8'h2C: k = 8'd29;
         8'h3C: k = 8'd30;
         8'h2A: k = 8'd31;
         8'h1D: k = 8'd32;
         8'h22: k = 8'd33;
         8'h35: k = 8'd34;
         8'h1A: k = 8'd35;
         8'h29: k = KEY_SPACE;
         8'h66: k = KEY_BKSP;
         8'h49: k = KEY_DOT;
         8'h5A: k = KEY_ENTER;
         8'h72: k = KEY_DOWN;
         8'h75: k = KEY_UP;
         default: k = KEY_NONE;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO; a push into a full FIFO succeeds only alongside a pop.
// The head reads as zero while empty.
module ps2_event_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign count   = cnt_q;
   assign dout    = empty ? '0 : mem[rd_q];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 byte stream parser with held-key map and buffered key events
// delivered over a valid/ready handshake.
module ps2_key_event_decoder
   import ps2_key_pkg::*;
#(
   parameter int FIFO_DEPTH      = 8,
   parameter int EMIT_RELEASE    = 1,
   parameter int SUPPRESS_REPEAT = 1
) (
   input  logic                         CLOCK_50,
   input  logic                         resetn,
   input  logic [7:0]                   received_data,
   input  logic                         received_data_en,
   output logic                         evt_valid,
   input  logic                         evt_ready,
   output logic [7:0]                   evt_code,
   output logic                         evt_release,
   output logic                         evt_extended,
   output logic [7:0]                   evt_raw,
   output logic [127:0]                 key_held,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         overflow
);

   parse_state_t state_q, state_d;
   logic [2:0]   skip_q, skip_d;
   logic         done, rel, ext;
   logic [7:0]   code;
   logic         tracked, is_held, push;
   logic [127:0] held_q;
   logic         ovf_q;
   logic         full, empty;
   key_evt_t     evt_in, head;

   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      done    = 1'b0;
      rel     = 1'b0;
      ext     = 1'b0;
      if (received_data_en) begin
         unique case (state_q)
            ST_IDLE: begin
               if (received_data == SC_E0) state_d = ST_EXT;
               else if (received_data == SC_F0) state_d = ST_BRK;
               else if (received_data == SC_E1) begin
                  state_d = ST_PAUSE;
                  skip_d  = 3'd7;
               end else if (!is_ignored(received_data)) done = 1'b1;
            end
            ST_EXT: begin
               if (received_data == SC_F0) state_d = ST_EXT_BRK;
               else if (received_data != SC_E0) begin
                  done    = 1'b1;
                  ext     = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_BRK: begin
               done    = 1'b1;
               rel     = 1'b1;
               state_d = ST_IDLE;
            end
            ST_EXT_BRK: begin
               done    = 1'b1;
               rel     = 1'b1;
               ext     = 1'b1;
               state_d = ST_IDLE;
            end
            ST_PAUSE: begin
               skip_d = skip_q - 3'd1;
               if (skip_q == 3'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Filtering: repeats of held keys and (optionally) breaks never reach the FIFO.
   assign code    = map_scancode(received_data);
   assign tracked = !code[7];
   assign is_held = tracked && held_q[code[6:0]];
   assign push    = done && (rel ? (EMIT_RELEASE != 0)
                                 : !((SUPPRESS_REPEAT != 0) && is_held));

   assign evt_in.code = code;
   assign evt_in.brk  = rel;
   assign evt_in.ext  = ext;
   assign evt_in.raw  = received_data;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         skip_q  <= 3'd0;
         held_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
         if (done && tracked) held_q[code[6:0]] <= !rel;
         if (push && full && !evt_ready) ovf_q <= 1'b1;
      end
   end

   ps2_event_fifo #(
      .WIDTH ($bits(key_evt_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLOCK_50),
      .rst_n (resetn),
      .push  (push),
      .din   (evt_in),
      .pop   (evt_ready),
      .dout  (head),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   assign evt_valid    = !empty;
   assign evt_code     = head.code;
   assign evt_release  = head.brk;
   assign evt_extended = head.ext;
   assign evt_raw      = head.raw;
   assign key_held     = held_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: four parameter variants share one byte
// stream and are compared every cycle against a queue-based reference model.
module tb_ps2_key_event_decoder;

   logic         clk = 1'b0;
   logic         resetn;
   logic [7:0]   data;
   logic         en;
   logic [3:0]   rdy;

   logic         ev_valid [4];
   logic [7:0]   ev_code  [4];
   logic         ev_rel   [4];
   logic         ev_ext   [4];
   logic [7:0]   ev_raw   [4];
   logic [127:0] held     [4];
   logic         ovf      [4];
   logic [3:0]   cnt_a    [4];
   logic [3:0]   c0, c1, c2;
   logic [2:0]   c3;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   ps2_key_event_decoder dut0 (
      .CLOCK_50(clk), .resetn(resetn), .received_data(data),
      .received_data_en(en), .evt_valid(ev_valid[0]), .evt_ready(rdy[0]),
      .evt_code(ev_code[0]), .evt_release(ev_rel[0]),
      .evt_extended(ev_ext[0]), .evt_raw(ev_raw[0]), .key_held(held[0]),
      .fifo_count(c0), .overflow(ovf[0]));

   ps2_key_event_decoder #(.SUPPRESS_REPEAT(0)) dut1 (
      .CLOCK_50(clk), .resetn(resetn), .received_data(data),
      .received_data_en(en), .evt_valid(ev_valid[1]), .evt_ready(rdy[1]),
      .evt_code(ev_code[1]), .evt_release(ev_rel[1]),
      .evt_extended(ev_ext[1]), .evt_raw(ev_raw[1]), .key_held(held[1]),
      .fifo_count(c1), .overflow(ovf[1]));

   ps2_key_event_decoder #(.EMIT_RELEASE(0)) dut2 (
      .CLOCK_50(clk), .resetn(resetn), .received_data(data),
      .received_data_en(en), .evt_valid(ev_valid[2]), .evt_ready(rdy[2]),
      .evt_code(ev_code[2]), .evt_release(ev_rel[2]),
      .evt_extended(ev_ext[2]), .evt_raw(ev_raw[2]), .key_held(held[2]),
      .fifo_count(c2), .overflow(ovf[2]));

   ps2_key_event_decoder #(.FIFO_DEPTH(4)) dut3 (
      .CLOCK_50(clk), .resetn(resetn), .received_data(data),
      .received_data_en(en), .evt_valid(ev_valid[3]), .evt_ready(rdy[3]),
      .evt_code(ev_code[3]), .evt_release(ev_rel[3]),
      .evt_extended(ev_ext[3]), .evt_raw(ev_raw[3]), .key_held(held[3]),
      .fifo_count(c3), .overflow(ovf[3]));

   assign cnt_a[0] = c0;
   assign cnt_a[1] = c1;
   assign cnt_a[2] = c2;
   assign cnt_a[3] = {1'b0, c3};

   // Reference model: per-variant config, held set, event queue, sticky overflow.
   int          depth_c [4] = '{8, 8, 8, 4};
   bit          sup_c   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   bit          emit_c  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
   logic [127:0] held_m [4];
   logic        ovf_m   [4];
   logic [17:0] q [4][$];
   bit          m_ext, m_brk;
   int          m_pause;

   logic [7:0] digit_sc  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                  8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
                                  8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
                                  8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                  8'h35, 8'h1A};
   logic [7:0] pool [20] = '{8'h1C, 8'h32, 8'h21, 8'h45, 8'h16, 8'h29, 8'h66,
                             8'h49, 8'h5A, 8'h72, 8'h75, 8'h05, 8'h76, 8'hE0,
                             8'hF0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h00};

   function automatic int ref_map(input logic [7:0] b);
      for (int k = 0; k < 10; k++) if (digit_sc[k] == b) return k;
      for (int k = 0; k < 26; k++) if (letter_sc[k] == b) return 10 + k;
      if (b == 8'h29) return 36;
      if (b == 8'h66) return 37;
      if (b == 8'h49) return 38;
      if (b == 8'h5A) return 98;
      if (b == 8'h72) return 99;
      if (b == 8'h75) return 100;
      return 255;
   endfunction

   task automatic model_reset();
      m_ext = 0;
      m_brk = 0;
      m_pause = 0;
      for (int i = 0; i < 4; i++) begin
         held_m[i] = '0;
         ovf_m[i] = 1'b0;
         q[i].delete();
      end
   endtask

   task automatic model_edge(input logic e, input logic [7:0] b);
      bit done, r, x, pu, pop, full;
      int c;
      done = 0; r = 0; x = 0;
      if (e) begin
         if (m_pause > 0) m_pause--;
         else if (m_brk) begin
            done = 1; r = 1; x = m_ext; m_brk = 0; m_ext = 0;
         end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1;
            else if (b != 8'hE0) begin done = 1; x = 1; m_ext = 0; end
         end else if (b == 8'hE0) m_ext = 1;
         else if (b == 8'hF0) m_brk = 1;
         else if (b == 8'hE1) m_pause = 7;
         else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF})) done = 1;
      end
      c = ref_map(b);
      for (int i = 0; i < 4; i++) begin
         pu = 0;
         if (done) begin
            if (r) begin
               pu = emit_c[i];
               if (c != 255) held_m[i][c] = 1'b0;
            end else begin
               pu = !(sup_c[i] && c != 255 && held_m[i][c]);
               if (c != 255) held_m[i][c] = 1'b1;
            end
         end
         pop  = rdy[i] && q[i].size() > 0;
         full = q[i].size() == depth_c[i];
         if (pop) void'(q[i].pop_front());
         if (pu) begin
            if (!full || pop) q[i].push_back({8'(c), r, x, b});
            else ovf_m[i] = 1'b1;
         end
      end
   endtask

   task automatic chk(input string tag, input int idx,
                      input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s[%0d] got %0h expected %0h", tag, idx, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [17:0] h;
      for (int i = 0; i < 4; i++) begin
         chk("valid", i, 128'(ev_valid[i]), 128'(q[i].size() != 0));
         chk("count", i, 128'(cnt_a[i]), 128'(q[i].size()));
         chk("overflow", i, 128'(ovf[i]), 128'(ovf_m[i]));
         chk("key_held", i, held[i], held_m[i]);
         if (q[i].size() != 0) begin
            h = q[i][0];
            chk("code", i, 128'(ev_code[i]), 128'(h[17:10]));
            chk("release", i, 128'(ev_rel[i]), 128'(h[9]));
            chk("extended", i, 128'(ev_ext[i]), 128'(h[8]));
            chk("raw", i, 128'(ev_raw[i]), 128'(h[7:0]));
         end
      end
   endtask

   task automatic check_zero();
      for (int i = 0; i < 4; i++) begin
         chk("rst_valid", i, 128'(ev_valid[i]), 128'(0));
         chk("rst_count", i, 128'(cnt_a[i]), 128'(0));
         chk("rst_ovf", i, 128'(ovf[i]), 128'(0));
         chk("rst_held", i, held[i], 128'(0));
         chk("rst_head", i, 128'({ev_code[i], ev_rel[i], ev_ext[i], ev_raw[i]}),
             128'(0));
      end
   endtask

   task automatic step(input logic e, input logic [7:0] b);
      @(negedge clk);
      data = b;
      en = e;
      @(posedge clk);
      model_edge(e, b);
      #1;
      check_all();
   endtask

   task automatic send(input logic [7:0] b);
      step(1'b1, b);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      en = 1'b0;
      resetn = 1'b0;
      model_reset();
      #1;
      check_zero();
      @(posedge clk);
      #1;
      check_zero();
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b0;
      data = 8'h00;
      en = 1'b0;
      rdy = 4'hF;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero();
      @(negedge clk);
      resetn = 1'b1;

      // make / break of A
      send(8'h1C);
      chk("a_make_code", 0, 128'(ev_code[0]), 128'(10));
      chk("a_held", 0, 128'(held[0][10]), 128'(1));
      send(8'hF0);
      send(8'h1C);
      chk("a_brk_rel", 0, 128'(ev_rel[0]), 128'(1));
      chk("a_brk_held", 0, 128'(held[0][10]), 128'(0));

      // extended up arrow, then Pause sequence, then digit 0
      send(8'hE0); send(8'h75);
      chk("up_code", 0, 128'(ev_code[0]), 128'(100));
      chk("up_ext", 0, 128'(ev_ext[0]), 128'(1));
      send(8'hE0); send(8'hF0); send(8'h75);
      chk("up_brk", 0, 128'({ev_rel[0], ev_ext[0]}), 128'(3));
      foreach (pool[k]) if (k < 0) send(pool[k]);
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      chk("pause_none", 0, 128'(ev_valid[0]), 128'(0));
      send(8'h45);
      chk("zero_code", 0, 128'(ev_code[0]), 128'(0));

      // typematic repeat and release filtering
      pulse_reset();
      rdy = 4'h0;
      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
      chk("rep_sup", 0, 128'(c0), 128'(2));
      chk("rep_nosup", 1, 128'(c1), 128'(4));
      chk("rep_noemit", 2, 128'(c2), 128'(1));

      // overflow on depth 4, then push+pop while full
      pulse_reset();
      rdy = 4'h0;
      send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
      chk("ovf_count", 3, 128'(c3), 128'(4));
      chk("ovf_flag", 3, 128'(ovf[3]), 128'(1));
      chk("ovf_deep", 0, 128'(ovf[0]), 128'(0));
      rdy = 4'h8;
      send(8'h2B);
      chk("pp_count", 3, 128'(c3), 128'(4));
      chk("pp_head", 3, 128'(ev_code[3]), 128'(11));
      rdy = 4'hF;
      repeat (8) step(1'b0, 8'h00);
      chk("ovf_sticky", 3, 128'(ovf[3]), 128'(1));

      // reset mid-sequence discards E0 F0
      send(8'hE0); send(8'hF0);
      pulse_reset();
      send(8'h1C);
      chk("mid_rst", 0, 128'({ev_code[0], ev_rel[0], ev_ext[0]}),
          128'({8'd10, 2'b00}));

      // unmapped byte
      send(8'h05);
      chk("unmapped", 0, 128'(ev_code[0]), 128'(255));
      chk("unmapped_held", 0, held[0], 128'(1) << 10);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         rdy = 4'($urandom);
         if ($urandom_range(0, 9) < 7) send(pool[$urandom_range(0, 19)]);
         else step(1'b0, 8'($urandom));
      end
      rdy = 4'hF;
      repeat (10) step(1'b0, 8'h00);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/ps2_key_event_decoder.md
# ps2_key_event_decoder

Parametrised successor to the single-register keyboard decoder. Consumes the byte stream from `PS2_Controller`, parses make/break/extended/Pause sequences with a state machine, maps scancodes to the team keycode set, tracks held keys, and buffers complete key events in a FIFO with a valid/ready handshake. It sits between `PS2_Controller` and the processor's input port, so no keystroke is lost while the consumer is busy.

## Interface
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, 2..64.
- `EMIT_RELEASE`, 1: 1 enqueues break events; 0 enqueues make events only.
- `SUPPRESS_REPEAT`, 1: 1 drops a make for a key already held (typematic repeat).
- `CLOCK_50` in 1: system clock; all logic on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `received_data` in 8: byte from `PS2_Controller`.
- `received_data_en` in 1: one-cycle strobe qualifying `received_data`.
- `evt_valid` out 1: FIFO head valid.
- `evt_ready` in 1: consumer accepts the head when `evt_valid && evt_ready`.
- `evt_code` out 8: mapped keycode of the head (255 = unmapped).
- `evt_release` out 1: head is a break event.
- `evt_extended` out 1: head was E0-prefixed.
- `evt_raw` out 8: raw scancode of the head.
- `key_held` out 128: bit k set while mapped keycode k is down.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: occupancy.
- `overflow` out 1: sticky; set when an event is dropped because the FIFO is full.

## Operation
- Parser states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), PAUSE (inside an E1 sequence).
  - IDLE: E0 goes to EXT; F0 goes to BRK; E1 goes to PAUSE with skip counter 7; any other byte completes a make and stays in IDLE.
  - EXT: F0 goes to EXT_BRK; E0 stays in EXT; any other byte completes an extended make and returns to IDLE.
  - BRK and EXT_BRK: the next byte completes a break (extended in EXT_BRK) and returns to IDLE.
  - PAUSE: each byte decrements the counter; the state returns to IDLE when the counter reaches 0. No event is produced for Pause.
  - Bytes AA, FA, FE, 00 and FF arriving in IDLE are ignored and do not change state.
- Mapping is a pure function of the raw byte; the E0 prefix does not affect it.
  - Digits 0–9 map to 0–9; letters A–Z map to 10–35.
  - Space (29) maps to 36, backspace (66) to 37, period (49) to 38.
  - Enter (5A) maps to 98, down (72) to 99, up (75) to 100.
  - All other bytes map to 255.
- Held-key tracking:
  - Make with code < 128 sets `key_held[code]`; break clears it; code 255 is never tracked.
  - Repeat: a make whose code is already held is dropped when `SUPPRESS_REPEAT=1`.
  - A break whose code is not held still enqueues, provided `EMIT_RELEASE=1`.
- Each completed event that is not filtered becomes a push of {code, release, extended, raw}.
- FIFO behaviour:
  - Push when full and no pop in the same cycle: the event is dropped and `overflow` is set.
  - Push and pop in the same cycle when full: both succeed and the count is unchanged.
  - Pop when empty: no effect.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Reset values: parser IDLE; skip counter 0; FIFO empty; `evt_valid`, `overflow`, `key_held`, `fifo_count` all 0; `evt_code`, `evt_release`, `evt_extended`, `evt_raw` all 0.
- Reset asserted mid-sequence (for example after E0 F0) discards the partial sequence; the next byte is parsed from IDLE.

## Timing
- Parser, held map and FIFO all update on the `CLOCK_50` edge that samples `received_data_en=1`.
- Latency: the strobe is sampled at edge N, and `evt_valid` plus head fields are visible after edge N, i.e. the cycle following the strobe. Filtered events produce no `evt_valid` change.
- `key_held` changes after the same edge N.
- Head fields hold stable while `evt_valid && !evt_ready`.
- A pop at edge M presents the next entry after M, so there are no bubbles.
- Back-to-back strobes on consecutive cycles are each processed.
- `overflow` clears only on reset.

## Structure
- Package `ps2_key_pkg` holds:
  - scancode constants: E0, E1, F0, and the ignored bytes;
  - the parser state enum;
  - keycode constants for 36–38 and 98–100, plus KEY_NONE=255;
  - `map_scancode()`, the mapping function;
  - the event struct type.
- Sub-module `ps2_event_fifo`: a synchronous FIFO parametrised by width and depth, with count and full/empty outputs.
- Top level contains the parser FSM, filter logic and held bitmap, and instantiates `ps2_event_fifo`.

## Test plan
- Bytes 1C, F0, 1C with `evt_ready=1`: make event {code 10, release 0, extended 0, raw 1C}, then break event {10, 1, 0, 1C}; `key_held[10]` rises, then falls.
- Bytes E0 75, E0 F0 75: events {100, 0, 1, 75} and {100, 1, 1, 75}. Then E1 14 77 E1 F0 14 F0 77: no events, parser back in IDLE, and a following 45 yields code 0.
- `SUPPRESS_REPEAT=1`, bytes 1C 1C 1C F0 1C: exactly 2 events. With `SUPPRESS_REPEAT=0`: 4 events. With `EMIT_RELEASE=0`: make events only.
- `FIFO_DEPTH=4`, `evt_ready=0`, 5 makes: `fifo_count=4`, `overflow=1`, the 5th event is dropped. Then push and pop in the same cycle while full: count stays 4 and order is preserved.
- Bytes E0 F0, then `resetn` pulsed low, then 1C: single make {10, 0, 0}; all outputs read 0 during reset.
- Unmapped byte 05 (F1): event with code 255, raw 05; `key_held` unchanged.
